// File: rtl/n64_cursor_ctrl_pkg.sv
// Shared N64 controller definitions: status bit map, axis direction and axis FSM states.
package n64_pkg;
   localparam int B_A      = 29;
   localparam int B_B      = 28;
   localparam int B_Z      = 27;
   localparam int B_START  = 26;
   localparam int B_DUP    = 25;
   localparam int B_DDOWN  = 24;
   localparam int B_DLEFT  = 23;
   localparam int B_DRIGHT = 22;
   localparam int B_L      = 21;
   localparam int B_R      = 20;
   localparam int B_CUP    = 19;
   localparam int B_CRIGHT = 16;
   localparam int B_JX     = 8;
   localparam int B_JY     = 0;

   typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_NEG = 2'd1, DIR_POS = 2'd2} dir_e;
   typedef enum logic [1:0] {AX_IDLE = 2'd0, AX_HOLD = 2'd1, AX_REPEAT = 2'd2} axis_state_e;

   // {A,B,Z,Start,L,R,CUp,CDown,CLeft,CRight}
   function automatic logic [9:0] btn_vec(input logic [29:0] s);
      return {s[B_A:B_START], s[B_L:B_CRIGHT]};
   endfunction

   // POS when the stick is deflected positive inside the window, NEG for negative.
   function automatic dir_e stick_dir(input logic [7:0] j, input int lo, input int hi);
      int v;
      v = int'($signed(j));
      if (v > lo && v < hi) return DIR_POS;
      if (-v > lo && -v < hi) return DIR_NEG;
      return DIR_NONE;
   endfunction
endpackage

// File: rtl/n64_cursor_ctrl_if.sv
// Cursor front-end bus: controller status and size in, cursor/buttons/stick out.
interface n64_cursor_ctrl_if #(parameter int CW = 4, parameter int SW = 3);
   logic [29:0]   N64Status;
   logic          NewCursor;
   logic [SW-1:0] CursorXWidth;
   logic [SW-1:0] CursorYWidth;
   logic [CW-1:0] CursorX;
   logic [CW-1:0] CursorY;
   logic [9:0]    Buttons;
   logic          Moved;
   logic [7:0]    JoyX;
   logic [7:0]    JoyY;

   modport master (output N64Status, NewCursor, CursorXWidth, CursorYWidth,
                   input  CursorX, CursorY, Buttons, Moved, JoyX, JoyY);
   modport slave  (input  N64Status, NewCursor, CursorXWidth, CursorYWidth,
                   output CursorX, CursorY, Buttons, Moved, JoyX, JoyY);
endinterface

// File: rtl/n64_cursor_ctrl_axis_repeat.sv
// One cursor axis: press/hold-off/auto-repeat FSM plus clamp or wrap stepping.
module n64_axis_repeat import n64_pkg::*; #(
   parameter int CW            = 4,
   parameter int FIRST_DELAY   = 13500000,
   parameter int REPEAT_PERIOD = 3500000,
   parameter int WRAP          = 0
) (
   input  logic          Clock,
   input  logic          Reset,
   input  dir_e          req_i,
   input  logic [CW-1:0] max_i,
   input  logic          new_cursor_i,
   output logic [CW-1:0] coord_o
);
   localparam int TMAX = (FIRST_DELAY > REPEAT_PERIOD) ? FIRST_DELAY : REPEAT_PERIOD;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] T_FIRST = TW'(FIRST_DELAY - 1);
   localparam logic [TW-1:0] T_REP   = TW'(REPEAT_PERIOD - 1);

   axis_state_e   state_q;
   dir_e          dir_q;
   logic [TW-1:0] timer_q;
   logic [CW-1:0] coord_q;

   function automatic logic [CW-1:0] nxt(input dir_e d, input logic [CW-1:0] c,
                                         input logic [CW-1:0] m);
      if (d == DIR_NEG) return (c == '0) ? ((WRAP != 0) ? m : c) : c - CW'(1);
      if (d == DIR_POS) return (c >= m) ? ((WRAP != 0) ? '0 : c) : c + CW'(1);
      return c;
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset || new_cursor_i) begin
         state_q <= AX_IDLE;
         dir_q   <= DIR_NONE;
         timer_q <= '0;
         coord_q <= '0;
      end else begin
         case (state_q)
            AX_HOLD, AX_REPEAT: begin
               if (req_i == DIR_NONE) begin
                  state_q <= AX_IDLE;
                  dir_q   <= DIR_NONE;
               end else if (req_i != dir_q) begin
                  coord_q <= nxt(req_i, coord_q, max_i);
                  timer_q <= T_FIRST;
                  dir_q   <= req_i;
                  state_q <= AX_HOLD;
               end else if (timer_q == '0) begin
                  coord_q <= nxt(dir_q, coord_q, max_i);
                  timer_q <= T_REP;
                  state_q <= AX_REPEAT;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            default: begin
               if (req_i != DIR_NONE) begin
                  coord_q <= nxt(req_i, coord_q, max_i);
                  timer_q <= T_FIRST;
                  dir_q   <= req_i;
                  state_q <= AX_HOLD;
               end
            end
         endcase
         // A shrunk cursor overrides any step this cycle.
         if (coord_q > max_i) coord_q <= max_i;
      end
   end

   assign coord_o = coord_q;
endmodule

// File: rtl/n64_cursor_ctrl.sv
// N64 cursor/button front end: registers controller status, decodes per-axis
// requests, runs two auto-repeat axes and emits button edges and Moved.
module n64_cursor_ctrl import n64_pkg::*; #(
   parameter int GRID_W        = 16,
   parameter int GRID_H        = 16,
   parameter int CW            = 4,
   parameter int SW            = 3,
   parameter int FIRST_DELAY   = 13500000,
   parameter int REPEAT_PERIOD = 3500000,
   parameter int JOY_LO        = 32,
   parameter int JOY_HI        = 96,
   parameter int WRAP          = 0
) (
   input logic              Clock,
   input logic              Reset,
   n64_cursor_ctrl_if.slave bus
);
   logic [29:0]   s_q;
   logic [9:0]    bp_q;
   logic [9:0]    btn_q;
   logic          mov_q;
   logic [CW-1:0] xp_q, yp_q;
   logic [CW-1:0] cursor_x, cursor_y;
   logic [CW-1:0] max_x, max_y;
   dir_e          req_x, req_y, sx, sy;

   function automatic logic [CW-1:0] lim(input int grid, input logic [SW-1:0] w);
      int wi;
      wi = (w == '0) ? 1 : int'(w);
      return (wi >= grid) ? '0 : CW'(grid - wi);
   endfunction

   assign max_x = lim(GRID_W, bus.CursorXWidth);
   assign max_y = lim(GRID_H, bus.CursorYWidth);

   // D-pad beats the stick; with both D-pad directions held, NEG is tested first.
   // Stick Y is "up" for positive values, so its sense is swapped.
   always_comb begin
      sx = stick_dir(s_q[B_JX +: 8], JOY_LO, JOY_HI);
      sy = stick_dir(s_q[B_JY +: 8], JOY_LO, JOY_HI);
      req_x = sx;
      if (s_q[B_DLEFT])       req_x = DIR_NEG;
      else if (s_q[B_DRIGHT]) req_x = DIR_POS;
      req_y = (sy == DIR_POS) ? DIR_NEG : (sy == DIR_NEG) ? DIR_POS : DIR_NONE;
      if (s_q[B_DUP])         req_y = DIR_NEG;
      else if (s_q[B_DDOWN])  req_y = DIR_POS;
   end

   n64_axis_repeat #(.CW(CW), .FIRST_DELAY(FIRST_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
                     .WRAP(WRAP)) u_ax_x (
      .Clock(Clock), .Reset(Reset), .req_i(req_x), .max_i(max_x),
      .new_cursor_i(bus.NewCursor), .coord_o(cursor_x));

   n64_axis_repeat #(.CW(CW), .FIRST_DELAY(FIRST_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD),
                     .WRAP(WRAP)) u_ax_y (
      .Clock(Clock), .Reset(Reset), .req_i(req_y), .max_i(max_y),
      .new_cursor_i(bus.NewCursor), .coord_o(cursor_y));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         s_q   <= '0;
         bp_q  <= '0;
         btn_q <= '0;
         xp_q  <= '0;
         yp_q  <= '0;
         mov_q <= 1'b0;
      end else begin
         s_q   <= bus.N64Status;
         bp_q  <= btn_vec(s_q);
         btn_q <= btn_vec(s_q) & ~bp_q;
         xp_q  <= cursor_x;
         yp_q  <= cursor_y;
         mov_q <= (cursor_x != xp_q) || (cursor_y != yp_q);
      end
   end

   assign bus.CursorX = cursor_x;
   assign bus.CursorY = cursor_y;
   assign bus.Buttons = btn_q;
   assign bus.Moved   = mov_q;
   assign bus.JoyX    = s_q[B_JX +: 8];
   assign bus.JoyY    = s_q[B_JY +: 8];
endmodule

// File: tb/tb_n64_cursor_ctrl.sv
// Bench for n64_cursor_ctrl: clamp and wrap instances against an age-based reference model.
module tb_n64_cursor_ctrl;
   import n64_pkg::*;
   localparam int GW = 16, GH = 16, CW = 4, SW = 3, FD = 10, RP = 4, LO = 32, HI = 96;

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   n64_cursor_ctrl_if #(.CW(CW), .SW(SW)) bus ();
   n64_cursor_ctrl_if #(.CW(CW), .SW(SW)) bus_w ();
   assign bus_w.N64Status    = bus.N64Status;
   assign bus_w.NewCursor    = bus.NewCursor;
   assign bus_w.CursorXWidth = bus.CursorXWidth;
   assign bus_w.CursorYWidth = bus.CursorYWidth;

   n64_cursor_ctrl #(.GRID_W(GW), .GRID_H(GH), .CW(CW), .SW(SW), .FIRST_DELAY(FD),
      .REPEAT_PERIOD(RP), .JOY_LO(LO), .JOY_HI(HI), .WRAP(0))
      dut (.Clock(Clock), .Reset(Reset), .bus(bus));
   n64_cursor_ctrl #(.GRID_W(GW), .GRID_H(GH), .CW(CW), .SW(SW), .FIRST_DELAY(FD),
      .REPEAT_PERIOD(RP), .JOY_LO(LO), .JOY_HI(HI), .WRAP(1))
      dut_w (.Clock(Clock), .Reset(Reset), .bus(bus_w));

   int n_vec = 0, n_err = 0;
   bit chk_en = 1'b0;

   // Reference model: [w] 0=clamp 1=wrap, [a] 0=X 1=Y
   logic [29:0] m_s1, m_s2;
   int m_cur [2][2];
   int m_last [2][2];
   int m_age [2];
   int m_held [2];
   logic [9:0] m_btn;
   logic m_mov [2];

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   function automatic int stick(input logic [7:0] j);
      int v;
      v = int'($signed(j));
      if (v > LO && v < HI) return 2;
      if (-v > LO && -v < HI) return 1;
      return 0;
   endfunction

   // 0 none, 1 toward zero, 2 away from zero
   function automatic int req_of(input logic [29:0] s, input int a);
      int k;
      if (a == 0) begin
         if (s[23]) return 1;
         if (s[22]) return 2;
         return stick(s[15:8]);
      end
      if (s[25]) return 1;
      if (s[24]) return 2;
      k = stick(s[7:0]);
      return (k == 0) ? 0 : 3 - k;
   endfunction

   function automatic int lim(input int grid, input int w);
      int wi;
      wi = (w == 0) ? 1 : w;
      return (grid - wi < 0) ? 0 : grid - wi;
   endfunction

   function automatic logic [9:0] bv(input logic [29:0] s);
      return {s[29], s[28], s[27], s[26], s[21], s[20], s[19], s[18], s[17], s[16]};
   endfunction

   task automatic model_step();
      int mx [2];
      int r;
      bit stp;
      if (Reset) begin
         m_s1 = '0; m_s2 = '0; m_btn = '0;
         for (int w = 0; w < 2; w++) begin
            m_mov[w] = 1'b0;
            for (int a = 0; a < 2; a++) begin m_cur[w][a] = 0; m_last[w][a] = 0; end
         end
         for (int a = 0; a < 2; a++) begin m_age[a] = 0; m_held[a] = 0; end
         return;
      end
      for (int w = 0; w < 2; w++) begin
         m_mov[w] = (m_cur[w][0] != m_last[w][0]) || (m_cur[w][1] != m_last[w][1]);
         for (int a = 0; a < 2; a++) m_last[w][a] = m_cur[w][a];
      end
      mx[0] = lim(GW, int'(bus.CursorXWidth));
      mx[1] = lim(GH, int'(bus.CursorYWidth));
      for (int a = 0; a < 2; a++) begin
         r = req_of(m_s1, a);
         stp = 1'b0;
         if (bus.NewCursor || r == 0) m_held[a] = 0;
         else if (r != m_held[a]) begin m_held[a] = r; m_age[a] = 0; stp = 1'b1; end
         else begin
            m_age[a]++;
            stp = (m_age[a] >= FD) && ((m_age[a] - FD) % RP == 0);
         end
         for (int w = 0; w < 2; w++) begin
            if (bus.NewCursor) m_cur[w][a] = 0;
            else if (m_cur[w][a] > mx[a]) m_cur[w][a] = mx[a];
            else if (stp && r == 1) m_cur[w][a] = (m_cur[w][a] == 0) ? (w == 1 ? mx[a] : 0) : m_cur[w][a] - 1;
            else if (stp && r == 2) m_cur[w][a] = (m_cur[w][a] >= mx[a]) ? (w == 1 ? 0 : m_cur[w][a]) : m_cur[w][a] + 1;
         end
      end
      m_btn = bv(m_s1) & ~bv(m_s2);
      m_s2 = m_s1;
      m_s1 = bus.N64Status;
   endtask

   task automatic tick();
      @(negedge Clock);
      if (chk_en) begin
         chk("x",    int'(bus.CursorX),   m_cur[0][0]);
         chk("y",    int'(bus.CursorY),   m_cur[0][1]);
         chk("wx",   int'(bus_w.CursorX), m_cur[1][0]);
         chk("wy",   int'(bus_w.CursorY), m_cur[1][1]);
         chk("btn",  int'(bus.Buttons),   int'(m_btn));
         chk("mov",  int'(bus.Moved),     int'(m_mov[0]));
         chk("wmov", int'(bus_w.Moved),   int'(m_mov[1]));
         chk("jx",   int'(bus.JoyX),      int'(m_s1[15:8]));
         chk("jy",   int'(bus.JoyY),      int'(m_s1[7:0]));
      end
      @(posedge Clock);
      model_step();
      #1;
   endtask

   task automatic set_st(input int bit_a, input int bit_b, input logic [7:0] jx, input logic [7:0] jy);
      logic [29:0] st;
      st = '0;
      if (bit_a >= 0) st[bit_a] = 1'b1;
      if (bit_b >= 0) st[bit_b] = 1'b1;
      st[15:8] = jx;
      st[7:0] = jy;
      bus.N64Status = st;
   endtask

   task automatic clear_cursor();
      set_st(-1, -1, 8'h00, 8'h00);
      bus.NewCursor = 1'b1;
      tick();
      bus.NewCursor = 1'b0;
      repeat (2) tick();
   endtask

   logic [7:0] jt [12] = '{8'h00, 8'h10, 8'h20, 8'h21, 8'h30, 8'h5F,
                           8'h60, 8'h70, 8'h80, 8'hD0, 8'hA1, 8'hE0};

   initial begin
      int cnt, hold, sel;
      logic [29:0] st;
      Reset = 1'b1;
      bus.NewCursor = 1'b0;
      bus.CursorXWidth = 3'd1;
      bus.CursorYWidth = 3'd1;
      set_st(B_DRIGHT, -1, 8'h00, 8'h00);
      @(posedge Clock);
      model_step();
      #1;
      chk_en = 1'b1;
      repeat (3) tick();
      chk("rst_x", int'(bus.CursorX), 0);

      // DRight held through reset: first step at release+2, repeats at +12, +16, +20
      Reset = 1'b0;
      repeat (2) tick();
      chk("rep_x2", int'(bus.CursorX), 1);
      repeat (9) tick();
      chk("rep_x11", int'(bus.CursorX), 1);
      tick();
      chk("rep_x12", int'(bus.CursorX), 2);
      repeat (8) tick();
      chk("rep_x20", int'(bus.CursorX), 4);

      // DDown saturates at 16-5, then DUp moves back immediately
      bus.CursorYWidth = 3'd5;
      set_st(B_DDOWN, -1, 8'h00, 8'h00);
      repeat (80) tick();
      chk("ysat", int'(bus.CursorY), 11);
      set_st(B_DUP, -1, 8'h00, 8'h00);
      repeat (2) tick();
      chk("yup", int'(bus.CursorY), 10);

      // DLeft tap at column 0: wrap to max, clamp stays
      clear_cursor();
      set_st(B_DLEFT, -1, 8'h00, 8'h00);
      tick();
      set_st(-1, -1, 8'h00, 8'h00);
      tick();
      chk("wrap1", int'(bus_w.CursorX), 15);
      chk("clampl", int'(bus.CursorX), 0);
      bus.CursorXWidth = 3'd3;
      clear_cursor();
      set_st(B_DLEFT, -1, 8'h00, 8'h00);
      tick();
      set_st(-1, -1, 8'h00, 8'h00);
      tick();
      chk("wrap3", int'(bus_w.CursorX), 13);
      bus.CursorXWidth = 3'd1;
      clear_cursor();

      // Stick windows and D-pad priority
      set_st(-1, -1, 8'h30, 8'h00); repeat (12) tick();
      set_st(-1, -1, 8'hD0, 8'h00); repeat (12) tick();
      set_st(-1, -1, 8'h10, 8'h00); repeat (6) tick();
      set_st(-1, -1, 8'h70, 8'h00); repeat (6) tick();
      set_st(-1, -1, 8'h80, 8'h00); repeat (6) tick();
      set_st(-1, -1, 8'h30, 8'h00); repeat (3) tick();
      set_st(B_DLEFT, -1, 8'h30, 8'h00); repeat (12) tick();

      // A held: one pulse; re-press: one more; A+Start together
      set_st(-1, -1, 8'h00, 8'h00); repeat (3) tick();
      set_st(B_A, -1, 8'h00, 8'h00);
      cnt = 0;
      repeat (50) begin tick(); cnt += int'(bus.Buttons[9]); end
      chk("a_once", cnt, 1);
      set_st(-1, -1, 8'h00, 8'h00); repeat (3) tick();
      set_st(B_A, -1, 8'h00, 8'h00);
      cnt = 0;
      repeat (10) begin tick(); cnt += int'(bus.Buttons[9]); end
      chk("a_again", cnt, 1);
      set_st(-1, -1, 8'h00, 8'h00); repeat (3) tick();
      set_st(B_A, B_START, 8'h00, 8'h00);
      repeat (2) tick();
      chk("a_start", int'(bus.Buttons), 'h240);
      set_st(-1, -1, 8'h00, 8'h00); repeat (3) tick();

      // Width grows with cursor at >=12: forced to 11 and Moved follows
      clear_cursor();
      set_st(B_DRIGHT, -1, 8'h00, 8'h00);
      cnt = 0;
      while (m_cur[0][0] < 12 && cnt < 200) begin tick(); cnt++; end
      chk("reach12", int'(cnt < 200), 1);
      set_st(-1, -1, 8'h00, 8'h00);
      repeat (4) tick();
      bus.CursorXWidth = 3'd5;
      tick();
      chk("shrink", int'(bus.CursorX), 11);
      tick();
      chk("shr_mov", int'(bus.Moved), 1);
      bus.CursorXWidth = 3'd1;

      // NewCursor mid-repeat, direction still held: fresh step next
      clear_cursor();
      set_st(B_DRIGHT, -1, 8'h00, 8'h00);
      repeat (20) tick();
      bus.NewCursor = 1'b1;
      tick();
      bus.NewCursor = 1'b0;
      chk("nc_x0", int'(bus.CursorX), 0);
      tick();
      chk("nc_x1", int'(bus.CursorX), 1);

      // Random phase
      hold = 0;
      repeat (2500) begin
         if (hold == 0) begin
            st = '0;
            st[29:26] = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            st[21:16] = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
            sel = $urandom_range(0, 9);
            case (sel)
               1: st[25] = 1'b1;
               2: st[24] = 1'b1;
               3: st[23] = 1'b1;
               4: st[22] = 1'b1;
               5: begin st[25] = 1'b1; st[24] = 1'b1; end
               6: begin st[23] = 1'b1; st[22] = 1'b1; end
               7: begin st[25] = 1'b1; st[22] = 1'b1; end
               default: ;
            endcase
            st[15:8] = jt[$urandom_range(0, 11)];
            st[7:0] = jt[$urandom_range(0, 11)];
            bus.N64Status = st;
            hold = $urandom_range(1, 25);
         end
         hold--;
         bus.NewCursor = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 99) == 0) bus.CursorXWidth = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) bus.CursorYWidth = 3'($urandom_range(0, 7));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/n64_cursor_ctrl.md
Name: n64_cursor_ctrl

Overview:
- Successor cursor/button front end for the N64 controller path; sits between the N64 status poller and the game FSM.
- Moves a rectangular cursor of run-time size (CursorXWidth x CursorYWidth) over a parametrised GRID_W x GRID_H board, from D-pad or analog stick.
- Per-axis auto-repeat: immediate step on press, hold-off delay, then periodic steps. Clamp or wrap at the board edge.
- Emits one-cycle rising-edge pulses for all 10 digital buttons and a Moved strobe.

Parameters:
GRID_W, 16, board columns (2..256)
GRID_H, 16, board rows (2..256)
CW, 4, cursor coordinate width; CW >= clog2(max(GRID_W,GRID_H))
SW, 3, width of CursorXWidth/CursorYWidth
FIRST_DELAY, 13500000, cycles from first step to first repeat (0.5 s at 27 MHz)
REPEAT_PERIOD, 3500000, cycles between repeat steps
JOY_LO, 32, stick magnitude must be > JOY_LO to count as deflected
JOY_HI, 96, stick magnitude must be < JOY_HI (glitch reject)
WRAP, 0, 0 = clamp at edges, 1 = wrap around

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high
N64Status  in  30  [29]A [28]B [27]Z [26]Start [25]DUp [24]DDown [23]DLeft [22]DRight [21]L [20]R [19:16]CUp,CDown,CLeft,CRight [15:8]JoyX [7:0]JoyY; JoyX/JoyY are signed two's complement
NewCursor  in  1  synchronous return of the cursor to (0,0)
CursorXWidth  in  SW  cursor width in cells (0 is treated as 1)
CursorYWidth  in  SW  cursor height in cells (0 is treated as 1)
CursorX  out  CW  left column
CursorY  out  CW  top row
Buttons  out  10  rising-edge pulses {A,B,Z,Start,L,R,CUp,CDown,CLeft,CRight}
Moved  out  1  pulses the cycle after CursorX or CursorY changes
JoyX  out  8  JoyX registered from N64Status
JoyY  out  8  JoyY registered from N64Status

Behaviour:
- Reset: CursorX=0, CursorY=0, Buttons=0, Moved=0, JoyX=JoyY=0, both axis FSMs IDLE, timers 0, edge-history registers 0.
- N64Status is registered once (stage S). All decisions use S and the previous S, so buttons pulse exactly 1 cycle after the registered rising edge, for one cycle.
- Axis request, computed per axis with D-pad priority over the stick:
  - Y: DUp -> NEG, else DDown -> POS, else stick.
  - Stick Y: JoyY in (JOY_LO, JOY_HI) -> NEG (up); -JoyY in (JOY_LO, JOY_HI) -> POS.
  - X: DLeft -> NEG, else DRight -> POS, else stick.
  - Stick X: -JoyX in (JOY_LO, JOY_HI) -> NEG; JoyX in (JOY_LO, JOY_HI) -> POS.
  - If both D-pad directions are held, NEG wins.
  - Magnitude is computed in 9 bits, so -128 is handled correctly.
  - Otherwise NONE.
- Axis FSM (one instance each for X and Y): IDLE, HOLD, REPEAT.
  - IDLE & req!=NONE -> step once, load timer=FIRST_DELAY-1, go to HOLD, latch dir.
  - HOLD: decrement timer. At 0: step, load REPEAT_PERIOD-1, go to REPEAT.
  - REPEAT: at timer 0: step, reload REPEAT_PERIOD-1.
  - From HOLD or REPEAT: req==NONE -> IDLE with no step. req != latched dir -> behaves as a new press from IDLE (step, HOLD).
- Step limit: MaxX = GRID_W - max(CursorXWidth,1), computed in CW+1 bits and floored at 0. Same for Y.
  - Clamp mode (WRAP=0): NEG at 0 and POS at Max are no-ops. Timers still run, and Moved is not asserted.
  - Wrap mode (WRAP=1): NEG at 0 -> Max; POS at Max -> 0.
- If a size input shrinks so that Cursor > Max, Cursor is forced to Max on the next cycle. Moved asserts.
- Priority: Reset > NewCursor > size-shrink clamp > steps.
  - NewCursor also returns both FSMs to IDLE. A direction still held after NewCursor counts as a new press on the following cycle.
- X and Y step independently in the same cycle; diagonal moves are allowed.
- Latency: direction asserted on N64Status at cycle t -> cursor updated at t+2; Moved high at t+3.

Decomposition:
- Shared package n64_pkg holds:
  - bit-index constants for the N64Status fields;
  - the dir enum (NONE, NEG, POS);
  - the axis-state enum (IDLE, HOLD, REPEAT).
- One sub-module, n64_axis_repeat, is instantiated twice.
  - Inputs: req, Max, NewCursor.
  - Output: a coordinate of CW bits.
  - Holds the FSM, the timer and the clamp/wrap step.
- The top level holds input registering, request decode, button edge detection and Moved.

Test Plan:
All scenarios use FIRST_DELAY=10, REPEAT_PERIOD=4 and GRID 16x16 unless stated.
- Reset with DRight held -> CursorX=0 during reset. First release cycle +2 -> CursorX=1; 1 at +2..+11; steps to 2 at +12, 3 at +16, 4 at +20.
- DDown held 80 cycles with CursorYWidth=5 -> CursorY saturates at 11. No Moved pulse after the last step. DUp then moves to 10 immediately.
- WRAP=1, CursorX=0, single DLeft tap -> CursorX=15 (width 1). With CursorXWidth=3 -> CursorX=13.
- JoyX=0x30 -> right steps. JoyX=0xD0 -> left steps. JoyX=0x10, 0x70 or 0x80 -> no movement. DLeft with JoyX=0x30 -> left (D-pad wins).
- A pressed for 50 cycles -> Buttons[9] high exactly one cycle. A re-pressed after release -> one more pulse. A and Start pressed together -> both bits pulse in the same cycle.
- CursorX=12, CursorXWidth changed 1->5 -> CursorX=11 next cycle, Moved pulses. NewCursor during REPEAT -> (0,0), FSM IDLE, then a fresh step if the direction is still held.
